// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Loader session states.
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int LEN_BYTES  = 4;  // little-endian word count prefix
    localparam int WORD_BYTES = 4;  // bytes packed per imem word

    // True when a 32-bit word count does not fit in a memory of 2**aw words.
    function automatic logic len_too_big(input logic [31:0] n, input int aw);
        return n > 32'(2 ** aw);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, one-cycle byte/frame-error pulses.
// Latency: byte delivered ~2 cycles after the mid-point of its stop bit.
// Backpressure: none; the consumer must accept rx_valid in the cycle it pulses.
//
// Ports:
//   clk, reset (async active-low)
//   rxd           raw UART line, asynchronous to clk, idle high
//   rx_byte       received byte, valid while rx_valid pulses
//   rx_valid      one-cycle pulse at a good stop-bit sample
//   rx_frame_err  one-cycle pulse when the stop bit samples low (no byte delivered)
module uart_rx_core #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int TW = $clog2(DIV) + 1;
    localparam logic [TW-1:0] HALF_BIT = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_BIT = TW'(DIV - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    rx_state_t       rx_state;
    logic            rxd_meta;
    logic            rxd_sync;
    logic            rxd_prev;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta     <= 1'b1;
            rxd_sync     <= 1'b1;
            rxd_prev     <= 1'b1;
            rx_state     <= RX_IDLE;
            timer        <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rxd_meta     <= rxd;
            rxd_sync     <= rxd_meta;
            rxd_prev     <= rxd_sync;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;

            case (rx_state)
                RX_IDLE: begin
                    // Falling edge on the synchronised line starts the bit timer.
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        timer    <= '0;
                    end
                end
                RX_START: begin
                    if (timer == HALF_BIT) begin
                        timer   <= '0;
                        bit_cnt <= '0;
                        // A line that is high again at mid-start was a glitch.
                        rx_state <= rxd_sync ? RX_IDLE : RX_BITS;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (timer == FULL_BIT) begin
                        timer   <= '0;
                        shift   <= {rxd_sync, shift[7:1]};  // LSB first
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == FULL_BIT) begin
                        timer    <= '0;
                        rx_state <= RX_IDLE;
                        if (rxd_sync) begin
                            rx_byte  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a length-prefixed LE image and writes it into imem word by word.
// Latency: imem write issued 1 cycle after the 4th byte of each word is received.
// Backpressure: none; one write per 4 UART bytes, far below any imem write rate.
//
// Ports:
//   clk, reset (async active-low)
//   load_imem     level arm; rising edge starts a session, falling edge ends/aborts it
//   uart_rxd      UART RX line (8N1)
//   imem_wr_en    one-cycle write strobe; imem_wr_addr word address; imem_wr_data {b3,b2,b1,b0}
//   cpu_hold      keep CPU in reset; busy: session running
//   done, error   sticky status, cleared at the start of the next session
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR-of-data-bytes checksum byte.
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int IMEM_ADDR_WIDTH = 12,
    localparam int AW             = IMEM_ADDR_WIDTH - 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_imem,
    input  logic          uart_rxd,
    output logic          imem_wr_en,
    output logic [AW-1:0] imem_wr_addr,
    output logic [31:0]   imem_wr_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);
    localparam logic [1:0] LAST_LEN  = 2'(LEN_BYTES - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_frame_err;

    uart_rx_core #(
        .DIV (DIV)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rxd          (uart_rxd),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    state_t      state;
    logic        load_q;
    logic [1:0]  lane;
    logic [23:0] byte_shift;   // first three bytes of the current length/data word
    logic [AW:0] len_words;    // up to 2**AW words, hence one extra bit
    logic [AW:0] word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_acc;
`endif

    logic [31:0] full_word;
    logic        active;
    logic        last_word;

    assign full_word = {rx_byte, byte_shift};
    assign active    = (state == LEN) || (state == DATA) || (state == CSUM);
    assign last_word = ((word_cnt + 1'b1) == len_words);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            load_q       <= 1'b0;
            lane         <= '0;
            byte_shift   <= '0;
            len_words    <= '0;
            word_cnt     <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc     <= '0;
`endif
        end else begin
            load_q     <= load_imem;
            imem_wr_en <= 1'b0;

            // Losing the arm or a bad frame mid-session aborts before any further write.
            if (active && (!load_imem || rx_frame_err)) begin
                state <= ERR;
                error <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_imem && !load_q) begin
                            state    <= LEN;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            word_cnt <= '0;
                            lane     <= '0;
                            cpu_hold <= 1'b1;
                            busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_acc <= '0;
`endif
                        end
                    end
                    LEN: begin
                        if (rx_valid) begin
                            if (lane == LAST_LEN) begin
                                lane      <= '0;
                                len_words <= full_word[AW:0];
                                if (full_word == 32'd0) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end else if (len_too_big(full_word, AW)) begin
                                    state <= ERR;
                                    error <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= DATA;
                                end
                            end else begin
                                lane       <= lane + 1'b1;
                                byte_shift <= {rx_byte, byte_shift[23:8]};
                            end
                        end
                    end
                    DATA: begin
                        if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_acc <= csum_acc ^ rx_byte;
`endif
                            if (lane == LAST_LANE) begin
                                lane         <= '0;
                                imem_wr_en   <= 1'b1;
                                imem_wr_addr <= word_cnt[AW-1:0];
                                imem_wr_data <= full_word;
                                word_cnt     <= word_cnt + 1'b1;
                                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state <= CSUM;
`else
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
`endif
                                end
                            end else begin
                                lane       <= lane + 1'b1;
                                byte_shift <= {rx_byte, byte_shift[23:8]};
                            end
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CSUM: begin
                        if (rx_valid) begin
                            busy <= 1'b0;
                            if (rx_byte == csum_acc) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ERR;
                                error <= 1'b1;
                            end
                        end
                    end
`endif
                    DONE: begin
                        // done was raised on entry; the CPU is released one cycle later.
                        cpu_hold <= 1'b0;
                        if (!load_imem) begin
                            state <= IDLE;
                        end
                    end
                    ERR: begin
                        // A partial image must not run: hold until the arm is dropped.
                        if (!load_imem) begin
                            state    <= IDLE;
                            cpu_hold <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
